// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame length, FSM encoding, scan-code type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  // Start bit, 8 data bits, odd parity, stop bit
  localparam int FRAME_BITS = 11;
  localparam int CNT_W      = 4;
  localparam int BUF_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ps2_state_e;

  typedef logic [7:0] scan_code_t;

  // True when data bits plus parity bit contain an odd number of ones
  function automatic logic odd_parity_ok(input scan_code_t data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Scan-code FIFO, DEPTH entries of 8 bits, extra-MSB pointers for full/empty.
// Latency: a push is visible at the head one cycle after the write edge.
// Backpressure: push while full is accepted only with a same-cycle pop; otherwise it is dropped.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  scan_code_t wdata_i,
  input  logic       pop_i,
  output scan_code_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  scan_code_t  mem_q [DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A full FIFO can still take a write when the head slot frees up this cycle
  assign rd_en = pop_i && !empty_o;
  assign wr_en = push_i && (!full_o || rd_en);

  // Empty FIFO presents zero rather than a stale entry
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are only observable through the non-empty head
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard frame receiver feeding a scan-code FIFO (parity check when PS2_PARITY_CHECK_EN is defined).
// Latency: valid rises 2 clk cycles after the stop-bit falling edge is detected (plus 2-cycle sync delay).
// Backpressure: consumer pops with ready; good frames arriving to a full FIFO are dropped and flag overflow.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       overflow,
  output logic       parity_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]       clk_sync_q;
  logic [2:0]       data_sync_q;
  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BUF_W-1:0] shift_q, shift_d;
  logic             start_q, start_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             overflow_q;

  logic fall;
  logic bit_in;
  logic last_edge;
  logic tmo_hit;
  logic shift_en;
  logic in_done;
  logic framing_ok;
  logic good;
  logic push;
  logic pop;
  logic full;
  logic empty;

  assign fall      = (clk_sync_q[2:1] == 2'b10);
  assign bit_in    = data_sync_q[2];
  assign last_edge = (count_q == CNT_W'(FRAME_BITS - 1));
  assign tmo_hit   = (state_q == ST_SHIFT) && !fall &&
                     (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Three-flop synchronisers on both raw PS/2 lines (idle-high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
      data_sync_q <= {data_sync_q[1:0], ps2_data};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: 11 edges complete a frame, a long silence abandons it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fall) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (fall && last_edge) state_d = ST_DONE;
        else if (tmo_hit)      state_d = ST_IDLE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: sample on every edge while collecting, judge the frame in DONE
  always_comb begin
    shift_en = 1'b0;
    in_done  = 1'b0;
    unique case (state_q)
      ST_IDLE:  shift_en = fall;
      ST_SHIFT: shift_en = fall;
      ST_DONE:  in_done  = 1'b1;
      default:  ;
    endcase
  end

  // Datapath next values: bit counter, LSB-first shift buffer, start bit, silence timer
  always_comb begin
    count_d = count_q;
    shift_d = shift_q;
    start_d = start_q;
    tmo_d   = '0;
    if (shift_en) begin
      shift_d = {bit_in, shift_q[BUF_W-1:1]};
      if (state_q == ST_IDLE) begin
        start_d = bit_in;
        count_d = CNT_W'(1);
      end else if (last_edge) begin
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (tmo_hit) begin
      count_d = '0;
      shift_d = '0;
    end else if (state_q == ST_SHIFT) begin
      tmo_d = tmo_q + TW'(1);
    end
    if (in_done) count_d = '0;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      shift_q <= '0;
      start_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      count_q <= count_d;
      shift_q <= shift_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
    end
  end

  // Buffer after 11 edges: [7:0] data, [8] parity, [9] stop; start held separately
  assign framing_ok = !start_q && shift_q[9];

`ifdef PS2_PARITY_CHECK_EN
  logic perr_q;

  assign good = framing_ok && odd_parity_ok(shift_q[7:0], shift_q[8]);

  // Sticky bad-frame flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  perr_q <= 1'b0;
    else if (in_done && !good) perr_q <= 1'b1;
  end

  assign parity_err = perr_q;
`else
  logic parity_unused;

  assign parity_unused = shift_q[8];
  assign good          = framing_ok;
  assign parity_err    = 1'b0;
`endif

  assign push  = in_done && good;
  assign valid = !empty;
  assign pop   = valid && ready;

  // Sticky overflow: a good frame found the FIFO full with no pop to make room
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         overflow_q <= 1'b0;
    else if (push && full && !pop)   overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (shift_q[7:0]),
    .pop_i   (pop),
    .rdata_o (data_out),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed and randomized bench for ps2_scancode_rx against a queue-based frame model.
// Latency: checks valid timing relative to the stop-bit falling edge.
// Backpressure: exercises full FIFO, overflow drop and push-with-pop acceptance.
module tb_ps2_scancode_rx;

  localparam int DEPTH = 8;
  localparam int TO    = 5000;
  localparam int HALF  = 8;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       overflow;
  logic       parity_err;

  int         n_chk;
  int         n_fail;
  logic [7:0] exp_q[$];
  logic       exp_ovf;
  logic       exp_perr;

  ps2_scancode_rx #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame kinds: 0 good, 1 wrong parity, 2 start bit high, 3 stop bit low
  function automatic logic [10:0] mkframe(input logic [7:0] d, input int kind);
    logic par;
    logic start;
    logic stop;
    par   = ~(^d);
    start = 1'b0;
    stop  = 1'b1;
    if (kind == 1) par   = ~par;
    if (kind == 2) start = 1'b1;
    if (kind == 3) stop  = 1'b0;
    return {stop, par, d, start};
  endfunction

  // Reference: a frame is good by its start/stop/parity bits; good frames queue if room
  task automatic model_frame(input logic [10:0] f);
    logic       good;
    logic [7:0] d;
    d    = f[8:1];
    good = (f[0] == 1'b0) && (f[10] == 1'b1) &&
           (!PAR_CHK || ($countones({d, f[9]}) % 2 == 1));
    if (good) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else                      exp_ovf = 1'b1;
    end else if (PAR_CHK) begin
      exp_perr = 1'b1;
    end
  endtask

  task automatic model_pop();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, exp_q.size() != 0});
    chk({tag, ".data"}, {24'd0, data_out}, (exp_q.size() != 0) ? {24'd0, exp_q[0]} : 32'd0);
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    chk({tag, ".perr"}, {31'd0, parity_err}, {31'd0, exp_perr});
  endtask

  task automatic do_reset();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    ready    = 1'b0;
    rst      = 1'b1;
    cyc(2);
    rst      = 1'b0;
    cyc(2);
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_perr = 1'b0;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  // mode 0: plain frame; 1: also check valid timing (FIFO empty beforehand);
  // 2: hold ready exactly over the cycle the frame is written
  task automatic send_frame(input logic [10:0] f, input int mode);
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && mode != 0) begin
        cyc(3);
        if (mode == 1) chk("lat.before", {31'd0, valid}, 32'd0);
        if (mode == 2) ready = 1'b1;
        cyc(1);
        if (mode == 1) chk("lat.rise", {31'd0, valid}, 32'd1);
        ready = 1'b0;
        cyc(HALF - 4);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(HALF);
    if (mode == 2) model_pop();
    model_frame(f);
  endtask

  task automatic do_pop();
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    model_pop();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    do_reset();
    check_state("reset");

    // Single frame and its latency
    send_frame(mkframe(8'h1C, 0), 1);
    check_state("single");
    do_pop();
    check_state("single.pop");

    // Ordering of two frames
    send_frame(mkframe(8'hF0, 0), 0);
    send_frame(mkframe(8'h1C, 0), 0);
    check_state("two");
    do_pop();
    check_state("two.pop1");
    do_pop();
    check_state("two.pop2");
    do_pop();
    check_state("two.pop_empty");

    // Wrong parity
    send_frame(mkframe(8'h1C, 1), 0);
    check_state("badpar");
    do_reset();

    // Overflow with nine frames and no pops
    for (int i = 0; i < 9; i++) send_frame(mkframe(8'h40 + 8'(i), 0), 0);
    check_state("ovf");
    for (int i = 0; i < 8; i++) begin
      do_pop();
      check_state("ovf.drain");
    end
    do_reset();

    // Ninth frame arriving together with a pop
    for (int i = 0; i < 8; i++) send_frame(mkframe(8'h60 + 8'(i), 0), 0);
    send_frame(mkframe(8'h99, 0), 2);
    check_state("fullpop");
    for (int i = 0; i < 8; i++) begin
      do_pop();
      check_state("fullpop.drain");
    end

    // Partial frame abandoned after silence
    send_bits(mkframe(8'hA5, 0), 5);
    cyc(TO + 20);
    send_frame(mkframe(8'h32, 0), 0);
    check_state("timeout");
    do_pop();
    check_state("timeout.pop");

    // Reset in the middle of a frame
    send_bits(mkframe(8'h77, 0), 6);
    do_reset();
    send_frame(mkframe(8'h1C, 0), 0);
    check_state("midrst");
    do_pop();
    check_state("midrst.pop");

    // Randomized frames of all kinds with occasional pops
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      int         kind;
      d    = 8'($urandom);
      kind = $urandom_range(0, 5);
      if (kind > 3) kind = 0;
      send_frame(mkframe(d, kind), 0);
      check_state("rand");
      if ($urandom_range(0, 2) == 0) begin
        do_pop();
        check_state("rand.pop");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
